// File: rtl/regfile_mp.sv
// Multi-port register file: NR combinational read ports, two byte-enabled write
// ports (port 1 wins per byte), optional write-to-read bypass and a busy scoreboard.
module regfile_mp #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int NR       = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DW/8-1:0]     we0,
  input  logic [AW-1:0]       wa0,
  input  logic [DW-1:0]       wd0,
  input  logic [DW/8-1:0]     we1,
  input  logic [AW-1:0]       wa1,
  input  logic [DW-1:0]       wd1,
  input  logic [NR*AW-1:0]    rr,
  output logic [NR*DW-1:0]    rd,
  output logic [NR-1:0]       rd_busy,
  input  logic                sb_set,
  input  logic [AW-1:0]       sb_addr,
  output logic [AW:0]         busy_cnt
);

  localparam int BW    = DW / 8;
  localparam int DEPTH = 2 ** AW;

  logic [DEPTH-1:0][DW-1:0] rf_reg, rf_next;
  logic [DEPTH-1:0]         busy_reg, busy_next;
  logic [AW:0]              busy_cnt_reg, busy_cnt_next;

  // Port 1 is applied last so it overrides port 0 on a shared byte.
  always_comb begin
    rf_next = rf_reg;
    for (int b = 0; b < BW; b++) begin
      if (we0[b]) rf_next[wa0][8*b +: 8] = wd0[8*b +: 8];
      if (we1[b]) rf_next[wa1][8*b +: 8] = wd1[8*b +: 8];
    end
    if (ZERO_REG != 0) rf_next[0] = '0;
  end

  // Set is applied after the clears so a new producer wins over writeback.
  always_comb begin
    busy_next = busy_reg;
    if (|we0) busy_next[wa0] = 1'b0;
    if (|we1) busy_next[wa1] = 1'b0;
    if (sb_set) busy_next[sb_addr] = 1'b1;
    if (ZERO_REG != 0) busy_next[0] = 1'b0;
    busy_cnt_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_cnt_next = busy_cnt_next + (AW+1)'(busy_next[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_reg       <= '0;
      busy_reg     <= '0;
      busy_cnt_reg <= '0;
    end else begin
      rf_reg       <= rf_next;
      busy_reg     <= busy_next;
      busy_cnt_reg <= busy_cnt_next;
    end
  end

  assign busy_cnt = busy_cnt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NR; gi++) begin : g_rd
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          busy;

      assign addr = rr[gi*AW +: AW];

      always_comb begin
        data = rf_reg[addr];
        busy = busy_reg[addr];
        if (BYPASS != 0) begin
          for (int b = 0; b < BW; b++) begin
            if (we0[b] && (wa0 == addr)) data[8*b +: 8] = wd0[8*b +: 8];
            if (we1[b] && (wa1 == addr)) data[8*b +: 8] = wd1[8*b +: 8];
          end
          if (((|we0) && (wa0 == addr)) || ((|we1) && (wa1 == addr))) busy = 1'b0;
        end
        // Bypassed write data must not leak out while reset is held.
        if (((ZERO_REG != 0) && (addr == '0)) || !rst_n) begin
          data = '0;
          busy = 1'b0;
        end
      end

      assign rd[gi*DW +: DW] = data;
      assign rd_busy[gi]     = busy;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp against an array-based model of
// the register contents and the busy scoreboard.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  we0, we1;
  logic [4:0]  wa0, wa1, sb_addr;
  logic [31:0] wd0, wd1;
  logic [9:0]  rr;
  logic [63:0] rd;
  logic [1:0]  rd_busy;
  logic        sb_set;
  logic [5:0]  busy_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] m_rf[32];
  bit          m_busy[32];

  regfile_mp dut (
    .clk(clk), .rst_n(rst_n),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .rr(rr), .rd(rd), .rd_busy(rd_busy),
    .sb_set(sb_set), .sb_addr(sb_addr), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Value register a holds after this cycle's writes; with bypass this is also
  // what a read sees during the write cycle.
  function automatic logic [31:0] m_after(int a);
    logic [31:0] v = m_rf[a];
    for (int b = 0; b < 4; b++) begin
      if (we0[b] && wa0 == a) v[8*b +: 8] = wd0[8*b +: 8];
      if (we1[b] && wa1 == a) v[8*b +: 8] = wd1[8*b +: 8];
    end
    if (a == 0) v = '0;
    return v;
  endfunction

  function automatic bit m_rdbusy(int a);
    bit cleared = (we0 != 0 && wa0 == a) || (we1 != 0 && wa1 == a);
    if (a == 0) return 1'b0;
    return m_busy[a] && !cleared;
  endfunction

  function automatic int m_cnt();
    int n = 0;
    for (int a = 0; a < 32; a++) n += int'(m_busy[a]);
    return n;
  endfunction

  task automatic model_reset();
    for (int a = 0; a < 32; a++) begin
      m_rf[a]   = '0;
      m_busy[a] = 1'b0;
    end
  endtask

  task automatic model_edge();
    logic [31:0] nv[32];
    for (int a = 0; a < 32; a++) nv[a] = m_after(a);
    for (int a = 0; a < 32; a++) begin
      m_rf[a] = nv[a];
      if ((we0 != 0 && wa0 == a) || (we1 != 0 && wa1 == a)) m_busy[a] = 1'b0;
    end
    if (sb_set) m_busy[sb_addr] = 1'b1;
    m_busy[0] = 1'b0;
  endtask

  task automatic idle();
    we0 = '0; wa0 = '0; wd0 = '0;
    we1 = '0; wa1 = '0; wd1 = '0;
    sb_set = 1'b0; sb_addr = '0;
  endtask

  // Called 1 time unit after a rising edge with inputs already applied.
  task automatic tick();
    int a0, a1;
    #2;
    a0 = int'(rr[4:0]);
    a1 = int'(rr[9:5]);
    chk("rd0", {32'h0, rd[31:0]}, {32'h0, m_after(a0)});
    chk("rd1", {32'h0, rd[63:32]}, {32'h0, m_after(a1)});
    chk("rd_busy", {62'h0, rd_busy}, {62'h0, m_rdbusy(a1), m_rdbusy(a0)});
    $display("cyc %0d we0=%h wa0=%0d we1=%h wa1=%0d sb=%0d@%0d rr=%0d/%0d rd0=%h rd1=%h",
             cyc, we0, wa0, we1, wa1, sb_set, sb_addr, a0, a1, rd[31:0], rd[63:32]);
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    chk("busy_cnt", {58'h0, busy_cnt}, 64'(m_cnt()));
  endtask

  initial begin
    idle();
    rr    = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state over every address
    chk("rst_cnt", {58'h0, busy_cnt}, 64'h0);
    for (int a = 0; a < 32; a++) begin
      rr = {5'(a), 5'(a)};
      #1;
      chk("rst_rd0", {32'h0, rd[31:0]}, 64'h0);
      chk("rst_rd1", {32'h0, rd[63:32]}, 64'h0);
      chk("rst_busy", {62'h0, rd_busy}, 64'h0);
    end
    @(posedge clk); #1;

    // Partial write with bypass
    we0 = 4'hF; wa0 = 5'd3; wd0 = 32'h11223344; rr = {5'd0, 5'd3};
    tick();
    we0 = 4'b0101; wd0 = 32'hAABBCCDD;
    #1 chk("partial_byp", {32'h0, rd[31:0]}, 64'h11BB33DD);
    tick();
    idle();
    #1 chk("partial_next", {32'h0, rd[31:0]}, 64'h11BB33DD);
    tick();

    // Write conflict on the same register
    we0 = 4'hF; wa0 = 5'd7; wd0 = 32'h11111111;
    we1 = 4'b0011; wa1 = 5'd7; wd1 = 32'h2222FFFF; rr = {5'd3, 5'd7};
    #1 chk("conflict_byp", {32'h0, rd[31:0]}, 64'h1111FFFF);
    tick();
    idle();
    #1 chk("conflict_next", {32'h0, rd[31:0]}, 64'h1111FFFF);
    tick();

    // Zero register ignores write and scoreboard set
    we0 = 4'hF; wa0 = 5'd0; wd0 = 32'hDEADBEEF; sb_set = 1'b1; sb_addr = 5'd0; rr = {5'd0, 5'd0};
    #1 chk("zero_byp", {32'h0, rd[31:0]}, 64'h0);
    tick();
    idle();
    #1 chk("zero_rd", {32'h0, rd[31:0]}, 64'h0);
    chk("zero_busy", {62'h0, rd_busy}, 64'h0);
    chk("zero_cnt", {58'h0, busy_cnt}, 64'h0);
    tick();

    // Scoreboard: set, set+clear, clear
    sb_set = 1'b1; sb_addr = 5'd5; rr = {5'd5, 5'd5};
    tick();
    idle();
    #1 chk("sb_set_busy", {63'h0, rd_busy[0]}, 64'h1);
    chk("sb_set_cnt", {58'h0, busy_cnt}, 64'h1);
    sb_set = 1'b1; sb_addr = 5'd5; we0 = 4'hF; wa0 = 5'd5; wd0 = 32'h55555555;
    tick();
    idle();
    #1 chk("sb_both_busy", {63'h0, rd_busy[0]}, 64'h1);
    chk("sb_both_cnt", {58'h0, busy_cnt}, 64'h1);
    we1 = 4'b0001; wa1 = 5'd5; wd1 = 32'h000000AA;
    #1 chk("sb_clr_mask", {63'h0, rd_busy[0]}, 64'h0);
    tick();
    idle();
    #1 chk("sb_clr_busy", {63'h0, rd_busy[0]}, 64'h0);
    chk("sb_clr_cnt", {58'h0, busy_cnt}, 64'h0);

    // Reset in the middle of activity
    we0 = 4'hF; wa0 = 5'd4; wd0 = 32'h44444444;
    we1 = 4'hF; wa1 = 5'd9; wd1 = 32'h99999999; rr = {5'd9, 5'd4};
    tick();
    idle(); sb_set = 1'b1; sb_addr = 5'd4;
    tick();
    sb_addr = 5'd9;
    tick();
    idle();
    #1 chk("pre_rst_cnt", {58'h0, busy_cnt}, 64'h2);
    chk("pre_rst_rd0", {32'h0, rd[31:0]}, 64'h44444444);
    #1 rst_n = 1'b0;
    #1 chk("mid_rst_rd", rd, 64'h0);
    chk("mid_rst_cnt", {58'h0, busy_cnt}, 64'h0);
    chk("mid_rst_busy", {62'h0, rd_busy}, 64'h0);
    we0 = 4'hF; wa0 = 5'd4; wd0 = 32'hCAFEF00D; sb_set = 1'b1; sb_addr = 5'd4;
    #1 chk("rst_byp_rd", rd, 64'h0);
    @(posedge clk);
    #2 idle();
    rst_n = 1'b1;
    model_reset();
    #1 chk("lost_wr", {32'h0, rd[31:0]}, 64'h0);
    chk("lost_cnt", {58'h0, busy_cnt}, 64'h0);
    @(posedge clk); #1;

    // Randomised traffic focused on a few addresses to provoke collisions
    for (int n = 0; n < 400; n++) begin
      we0 = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      we1 = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      wa0 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      wa1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      wd0 = $urandom;
      wd1 = $urandom;
      sb_set  = ($urandom_range(0, 1) == 1);
      sb_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      rr = {5'($urandom_range(0, 8)), 5'($urandom_range(0, 8))};
      tick();
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", cyc, 0);
    $fatal(1, "bench timed out");
  end

endmodule
